mem_access: RTL
===============

MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 Parameters: TIMEOUT, 16, max cycles waiting for dmem_ack_i before abort; AW, 32, address/data width (`RegBus`).
REQ-002 Ports: clk in 1 clock; rst in 1 async active-high reset; valid_i in 1 EX/MEM slot holds live instr.
REQ-003 Ports: ctrl_wb_RegWrite_i, ctrl_wb_Mem2Reg_i, ctrl_mem_branch_i, ctrl_mem_read_i, ctrl_mem_write_i, alu_branch_take_i in 1 each, EX/MEM controls.
REQ-004 Ports: branch_pc_i in `InstAddrBus`; alu_result_i in 32 addr/result; mem_write_data_i in 32; mem_size_i in 3 (funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU); write_addr_i in `RegAddrBus`.
REQ-005 Ports: dmem_req_o out 1; dmem_we_o out 1; dmem_addr_o out 32 (word-aligned); dmem_wdata_o out 32; dmem_be_o out 4; dmem_ack_i in 1; dmem_rdata_i in 32.
REQ-006 Ports: stall_o out 1 (upstream holds EX/MEM); pc_src_o out 1; branch_pc_o out `InstAddrBus`; misalign_o out 1; bus_err_o out 1.
REQ-007 Ports to MEM/WB, all registered: valid_o, ctrl_wb_RegWrite_o, ctrl_wb_Mem2Reg_o out 1; mem_read_data_o, alu_result_o out 32; write_addr_o out `RegAddrBus`.

Function
REQ-008 memop = valid_i & (ctrl_mem_read_i | ctrl_mem_write_i); read and write both set is treated as write.
REQ-009 Aligned: B/BU always; H/HU iff addr[0]=0; W iff addr[1:0]=00; other mem_size_i codes count as misaligned.
REQ-010 FSM states IDLE, WAIT; reset state IDLE.
REQ-011 dmem_req_o (combinational) = (IDLE & memop & aligned) | WAIT; address/we/be/wdata driven from inputs whenever req high.
REQ-012 stall_o (combinational) = dmem_req_o & ~dmem_ack_i & ~timeout.
REQ-013 IDLE, req & ack same cycle: zero-wait completion, stay IDLE; req & ~ack: go WAIT, clear wait counter.
REQ-014 WAIT: counter increments each cycle without ack; ack -> complete, go IDLE; counter = TIMEOUT-1 without ack -> abort, bus_err_o pulses 1 cycle, go IDLE.
REQ-015 Store byte enables: SB 0001<<addr[1:0]; SH 0011<<addr[1:0]; SW 1111; wdata replicates byte x4 / half x2.
REQ-016 Load: select lane by addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend, LW pass; result -> mem_read_data_o on completion.
REQ-017 Misaligned memop: no request, misalign_o pulses 1 cycle, no stall, slot retires with RegWrite forced 0.
REQ-018 Aborted (timeout) access retires with RegWrite forced 0, mem_read_data_o 0.
REQ-019 Non-memop valid instr retires next clock edge (1-cycle latency); memop retires on edge where ack (or abort) seen.
REQ-020 On retire: valid_o=1, controls/alu_result/write_addr copied from inputs; cycles with stall_o=1 or valid_i=0 register valid_o=0, RegWrite_o=0.
REQ-021 pc_src_o (combinational) = valid_i & ctrl_mem_branch_i & alu_branch_take_i & ~stall_o; branch_pc_o = branch_pc_i.
REQ-022 dmem_ack_i while dmem_req_o=0 is ignored.

Reset
REQ-023 rst asynchronous active-high: state IDLE, counter 0, all registered outputs 0, bus_err_o/misalign_o 0.
REQ-024 rst mid-WAIT aborts access immediately; dmem_req_o drops in reset cycle; no retire.
REQ-025 First edge after rst deassertion operates normally.

Verification
REQ-026 LW addr 0x100, ack same cycle, rdata 0xDEADBEEF -> no stall, next edge mem_read_data_o=0xDEADBEEF, valid_o=1.
REQ-027 LB addr 0x103, rdata 0x80112233, ack after 3 cycles -> stall_o high 3 cycles, mem_read_data_o=0xFFFFFF80; LBU -> 0x00000080.
REQ-028 SH addr 0x102 data 0x0000ABCD -> dmem_be_o=1100, dmem_wdata_o=0xABCDABCD, dmem_we_o=1.
REQ-029 LW addr 0x101 -> misalign_o 1 cycle, dmem_req_o never high, retire with RegWrite_o=0.
REQ-030 LW, no ack for TIMEOUT=16 cycles -> bus_err_o pulse at cycle 16, stall released, RegWrite_o=0; rst at cycle 5 of WAIT -> req drops, outputs 0.
REQ-031 Branch=1, take=1, branch_pc_i=0x40 -> pc_src_o=1, branch_pc_o=0x40; take=0 -> pc_src_o=0.

Source files
------------

// File: rtl/mem_access_if.sv
// Data-memory bus between the MEM stage (master) and the memory/bus fabric (slave).
// Handshake: master holds req with stable addr/we/be/wdata until the cycle ack is high; ack with req low means nothing.
interface mem_access_if #(
   parameter int AW = 32
);
   logic          dmem_req_o;
   logic          dmem_we_o;
   logic [AW-1:0] dmem_addr_o;
   logic [AW-1:0] dmem_wdata_o;
   logic [3:0]    dmem_be_o;
   logic          dmem_ack_i;
   logic [AW-1:0] dmem_rdata_i;

   modport master (
      output dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o, dmem_be_o,
      input  dmem_ack_i, dmem_rdata_i
   );

   modport slave (
      input  dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o, dmem_be_o,
      output dmem_ack_i, dmem_rdata_i
   );
endinterface

// File: rtl/mem_access.sv
// MEM pipeline stage: issues aligned loads/stores on the data bus, waits for ack
// with a timeout, formats load data and registers the MEM/WB slot.
module mem_access #(
   parameter int TIMEOUT = 16,
   parameter int AW      = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          valid_i,
   input  logic          ctrl_wb_RegWrite_i,
   input  logic          ctrl_wb_Mem2Reg_i,
   input  logic          ctrl_mem_branch_i,
   input  logic          ctrl_mem_read_i,
   input  logic          ctrl_mem_write_i,
   input  logic          alu_branch_take_i,
   input  logic [31:0]   branch_pc_i,
   input  logic [AW-1:0] alu_result_i,
   input  logic [AW-1:0] mem_write_data_i,
   input  logic [2:0]    mem_size_i,
   input  logic [4:0]    write_addr_i,
   mem_access_if.master  dmem,
   output logic          stall_o,
   output logic          pc_src_o,
   output logic [31:0]   branch_pc_o,
   output logic          misalign_o,
   output logic          bus_err_o,
   output logic          valid_o,
   output logic          ctrl_wb_RegWrite_o,
   output logic          ctrl_wb_Mem2Reg_o,
   output logic [AW-1:0] mem_read_data_o,
   output logic [AW-1:0] alu_result_o,
   output logic [4:0]    write_addr_o,
   output logic          dbg_state_o
);
   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic          memop, aligned, req, ack, timeout, abort, misalign_now, done_read;
   logic [3:0]    be;
   logic [AW-1:0] wdata, lane, load_data;

   assign memop = valid_i & (ctrl_mem_read_i | ctrl_mem_write_i);

   always_comb begin
      aligned = 1'b0;
      case (mem_size_i)
         3'b000, 3'b100: aligned = 1'b1;
         3'b001, 3'b101: aligned = ~alu_result_i[0];
         3'b010:         aligned = (alu_result_i[1:0] == 2'b00);
         default:        aligned = 1'b0;
      endcase
   end

   // Reset gates the request so an in-flight access is dropped in the reset cycle itself.
   assign timeout      = (state == WAIT) && (cnt == CW'(TIMEOUT - 1));
   assign req          = ~rst & (((state == IDLE) & memop & aligned) | (state == WAIT));
   assign ack          = req & dmem.dmem_ack_i;
   assign abort        = timeout & ~dmem.dmem_ack_i;
   assign stall_o      = req & ~dmem.dmem_ack_i & ~timeout;
   assign misalign_now = (state == IDLE) & memop & ~aligned;
   assign done_read    = ack & ~ctrl_mem_write_i;

   always_comb begin
      be    = 4'b0000;
      wdata = mem_write_data_i;
      case (mem_size_i[1:0])
         2'b00: begin
            be    = 4'b0001 << alu_result_i[1:0];
            wdata = {4{mem_write_data_i[7:0]}};
         end
         2'b01: begin
            be    = 4'b0011 << alu_result_i[1:0];
            wdata = {2{mem_write_data_i[15:0]}};
         end
         2'b10:   be = 4'b1111;
         default: be = 4'b0000;
      endcase
   end

   assign dmem.dmem_req_o   = req;
   assign dmem.dmem_we_o    = req & ctrl_mem_write_i;
   assign dmem.dmem_addr_o  = req ? {alu_result_i[AW-1:2], 2'b00} : '0;
   assign dmem.dmem_be_o    = req ? be : 4'b0000;
   assign dmem.dmem_wdata_o = req ? wdata : '0;

   assign lane = dmem.dmem_rdata_i >> {alu_result_i[1:0], 3'b000};

   always_comb begin
      load_data = dmem.dmem_rdata_i;
      case (mem_size_i)
         3'b000:  load_data = {{(AW-8){lane[7]}}, lane[7:0]};
         3'b001:  load_data = {{(AW-16){lane[15]}}, lane[15:0]};
         3'b100:  load_data = {{(AW-8){1'b0}}, lane[7:0]};
         3'b101:  load_data = {{(AW-16){1'b0}}, lane[15:0]};
         default: load_data = dmem.dmem_rdata_i;
      endcase
   end

   assign pc_src_o    = valid_i & ctrl_mem_branch_i & alu_branch_take_i & ~stall_o;
   assign branch_pc_o = branch_pc_i;
   assign dbg_state_o = (state == WAIT);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state              <= IDLE;
         cnt                <= '0;
         misalign_o         <= 1'b0;
         bus_err_o          <= 1'b0;
         valid_o            <= 1'b0;
         ctrl_wb_RegWrite_o <= 1'b0;
         ctrl_wb_Mem2Reg_o  <= 1'b0;
         mem_read_data_o    <= '0;
         alu_result_o       <= '0;
         write_addr_o       <= '0;
      end else begin
         misalign_o <= misalign_now;
         bus_err_o  <= abort;
         case (state)
            IDLE: begin
               if (req && !dmem.dmem_ack_i) begin
                  state <= WAIT;
                  cnt   <= '0;
               end
            end
            WAIT: begin
               if (dmem.dmem_ack_i || timeout) state <= IDLE;
               else                            cnt   <= cnt + 1'b1;
            end
            default: state <= IDLE;
         endcase
         // A slot retires on every unstalled edge; failed accesses never write back.
         if (valid_i && !stall_o) begin
            valid_o            <= 1'b1;
            ctrl_wb_RegWrite_o <= ctrl_wb_RegWrite_i & ~misalign_now & ~abort;
            ctrl_wb_Mem2Reg_o  <= ctrl_wb_Mem2Reg_i;
            mem_read_data_o    <= done_read ? load_data : '0;
            alu_result_o       <= alu_result_i;
            write_addr_o       <= write_addr_i;
         end else begin
            valid_o            <= 1'b0;
            ctrl_wb_RegWrite_o <= 1'b0;
         end
      end
   end
endmodule
